tft_frame_capture: RTL and testbench

Single-clock TFT pixel-stream receiver. It is the sink end of the SoC's `RGB_O` / `RGB_EN_O` video output. Once armed, it waits for a frame start, then writes one complete active frame of 8-bit pixels into a BRAM frame buffer in raster order. It reports completion and line-length errors. Used as the loop-back capture path for the Sobel/VGA display chain and as the on-chip frame checker.

---
 rtl/tft_cap_pkg.sv | 23 ++
 rtl/tft_frame_capture_if.sv | 34 +++
 rtl/tft_cap_addr_gen.sv | 61 ++++++
 rtl/tft_frame_capture.sv | 169 ++++++++++++++++
 tb/tb_tft_frame_capture.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tft_cap_pkg.sv
// tft_cap_pkg
//   Shared types and constants for the TFT frame-capture block:
//   capture FSM state type, default frame geometry and checksum width,
//   plus a counter-width helper used by the address generator.
package tft_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int unsigned H_ACTIVE_DEF = 480;
    localparam int unsigned V_ACTIVE_DEF = 272;
    localparam int unsigned CHKSUM_W     = 16;

    // Bits needed to hold the values 0..n inclusive (counters reach n).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tft_frame_capture_if.sv
// tft_frame_capture_if
//   Pixel-stream input and BRAM write port of the frame-capture block.
//   master : video source / frame-buffer side (drives VSYNC_I, RGB_I,
//            RGB_EN_I; observes the BRAM write port)
//   slave  : capture block (samples the pixel stream; drives BRAM_WE_O,
//            BRAM_ADDR_O, BRAM_DATA_O)
interface tft_frame_capture_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              VSYNC_I;
    logic [7:0]        RGB_I;
    logic              RGB_EN_I;
    logic              BRAM_WE_O;
    logic [ADDR_W-1:0] BRAM_ADDR_O;
    logic [7:0]        BRAM_DATA_O;

    modport master (
        output VSYNC_I,
        output RGB_I,
        output RGB_EN_I,
        input  BRAM_WE_O,
        input  BRAM_ADDR_O,
        input  BRAM_DATA_O
    );

    modport slave (
        input  VSYNC_I,
        input  RGB_I,
        input  RGB_EN_I,
        output BRAM_WE_O,
        output BRAM_ADDR_O,
        output BRAM_DATA_O
    );
endinterface

// File: rtl/tft_cap_addr_gen.sv
// tft_cap_addr_gen
//   Pixel/line counters and raster address for the frame-capture block.
//   The address is line_base + x, where line_base advances by H_ACTIVE at
//   each line end (no multiplier).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart at x=0, y=0 (frame start)
//   pix        : accepted pixel this cycle (x advances)
//   eol        : RGB_EN falling edge seen this cycle
//   addr       : write address for the current pixel
//   room       : x < H_ACTIVE, pixel may be written
//   line_end   : eol with at least one pixel in the line
//   line_err   : line_end with a line length other than H_ACTIVE
//   frame_end  : line_end of the last active line
module tft_cap_addr_gen
    import tft_cap_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              pix,
    input  logic              eol,
    output logic [ADDR_W-1:0] addr,
    output logic              room,
    output logic              line_end,
    output logic              line_err,
    output logic              frame_end
);

    localparam int unsigned XW = cnt_width(H_ACTIVE);
    localparam int unsigned YW = cnt_width(V_ACTIVE);

    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] line_base_q;

    assign room      = (x_q < XW'(H_ACTIVE));
    assign line_end  = eol && (x_q != '0);
    assign line_err  = line_end && (x_q != XW'(H_ACTIVE));
    assign frame_end = line_end && (y_q == YW'(V_ACTIVE - 1));
    assign addr      = line_base_q + ADDR_W'(x_q);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
        end else if (line_end) begin
            x_q         <= '0;
            y_q         <= y_q + 1'b1;
            line_base_q <= line_base_q + ADDR_W'(H_ACTIVE);
        end else if (pix && room) begin
            x_q <= x_q + 1'b1;
        end
    end

endmodule

// File: rtl/tft_frame_capture.sv
// tft_frame_capture
//   Captures one active frame of 8-bit pixels from a TFT pixel stream into
//   a BRAM frame buffer in raster order, after being armed.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   ARM_I     : arm request (honoured in IDLE only; clears ERR_O/checksum)
//   vid       : pixel stream in (VSYNC_I, RGB_I, RGB_EN_I) and BRAM write
//               port out (BRAM_WE_O, BRAM_ADDR_O, BRAM_DATA_O)
//   BUSY_O    : high while waiting for VSYNC or capturing
//   DONE_O    : one-cycle pulse at frame completion
//   ERR_O     : sticky line-length / premature-VSYNC error
//   CHKSUM_O  : 16-bit wrap-around sum of written pixels; present only when
//               TFT_CAP_CHECKSUM_EN is defined
// Pixel path: a pixel sampled at edge N is held in a pending stage and
// reaches the BRAM port registers at edge N+1.
module tft_frame_capture
    import tft_cap_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ARM_I,
    tft_frame_capture_if.slave vid,
    output logic               BUSY_O,
    output logic               DONE_O,
    output logic               ERR_O
`ifdef TFT_CAP_CHECKSUM_EN
    ,
    output logic [CHKSUM_W-1:0] CHKSUM_O
`endif
);

    cap_state_t        state_q;
    cap_state_t        next_state;
    logic              vsync_q;
    logic              en_q;
    logic              vs_rise;
    logic              en_fall;
    logic              in_capture;
    logic              restart;
    logic              pix;
    logic              eol;
    logic              arm_clr;
    logic              err_set;
    logic [ADDR_W-1:0] addr;
    logic              room;
    logic              line_end;
    logic              line_err;
    logic              frame_end;
    logic              p_we_q;
    logic [ADDR_W-1:0] p_addr_q;
    logic [7:0]        p_data_q;

    assign vs_rise    = vid.VSYNC_I && !vsync_q;
    assign en_fall    = en_q && !vid.RGB_EN_I;
    assign in_capture = (state_q == CAPTURE);
    // A VSYNC rise wins over anything else in that cycle: the pixel or line
    // end sampled alongside it is discarded and counting restarts.
    assign restart    = vs_rise && ((state_q == WAIT_VS) || in_capture);
    assign pix        = in_capture && !vs_rise && vid.RGB_EN_I && room;
    assign eol        = in_capture && !vs_rise && en_fall;

    tft_cap_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (restart),
        .pix       (pix),
        .eol       (eol),
        .addr      (addr),
        .room      (room),
        .line_end  (line_end),
        .line_err  (line_err),
        .frame_end (frame_end)
    );

    always_comb begin
        next_state = state_q;
        arm_clr    = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ARM_I) begin
                    next_state = WAIT_VS;
                    arm_clr    = 1'b1;
                end
            end
            WAIT_VS: begin
                if (vs_rise) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    err_set = 1'b1;
                end else begin
                    if (vid.RGB_EN_I && !room) begin
                        err_set = 1'b1;
                    end
                    if (line_err) begin
                        err_set = 1'b1;
                    end
                    if (frame_end) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            vsync_q         <= 1'b0;
            en_q            <= 1'b0;
            BUSY_O          <= 1'b0;
            DONE_O          <= 1'b0;
            ERR_O           <= 1'b0;
            p_we_q          <= 1'b0;
            p_addr_q        <= '0;
            p_data_q        <= '0;
            vid.BRAM_WE_O   <= 1'b0;
            vid.BRAM_ADDR_O <= '0;
            vid.BRAM_DATA_O <= '0;
        end else begin
            state_q <= next_state;
            vsync_q <= vid.VSYNC_I;
            en_q    <= vid.RGB_EN_I;
            BUSY_O  <= (next_state == WAIT_VS) || (next_state == CAPTURE);
            DONE_O  <= (next_state == DONE);
            if (arm_clr) begin
                ERR_O <= 1'b0;
            end else if (err_set) begin
                ERR_O <= 1'b1;
            end
            p_we_q <= pix;
            if (pix) begin
                p_addr_q <= addr;
                p_data_q <= vid.RGB_I;
            end
            vid.BRAM_WE_O   <= p_we_q;
            vid.BRAM_ADDR_O <= p_addr_q;
            vid.BRAM_DATA_O <= p_data_q;
        end
    end

`ifdef TFT_CAP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || arm_clr || restart) begin
            CHKSUM_O <= '0;
        end else if (pix) begin
            CHKSUM_O <= CHKSUM_O + CHKSUM_W'(vid.RGB_I);
        end
    end
`endif

endmodule

// File: tb/tb_tft_frame_capture.sv
module tb_tft_frame_capture;
    import tft_cap_pkg::*;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned AW = 4;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int unsigned edg;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic ARM_I;
    logic BUSY_O;
    logic DONE_O;
    logic ERR_O;
`ifdef TFT_CAP_CHECKSUM_EN
    logic [15:0] CHKSUM_O;
`endif

    tft_frame_capture_if #(.ADDR_W(AW)) vid ();

    tft_frame_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ARM_I  (ARM_I),
        .vid    (vid.slave),
        .BUSY_O (BUSY_O),
        .DONE_O (DONE_O),
        .ERR_O  (ERR_O)
`ifdef TFT_CAP_CHECKSUM_EN
        ,
        .CHKSUM_O (CHKSUM_O)
`endif
    );

    always #5 clk = ~clk;

    int unsigned ecnt = 0;
    always @(posedge clk) ecnt++;

    // Observed BRAM writes and DONE pulses
    wr_t         got_q[$];
    int          done_cnt;
    int unsigned done_edge;
    logic        busy_at_done;

    always @(negedge clk) begin
        if (vid.BRAM_WE_O === 1'b1)
            got_q.push_back(wr_t'{32'(vid.BRAM_ADDR_O), 32'(vid.BRAM_DATA_O), ecnt});
        if (DONE_O === 1'b1) begin
            done_cnt++;
            done_edge    = ecnt;
            busy_at_done = BUSY_O;
        end
    end

    // Reference model: frame geometry rules applied per line
    wr_t         exp_q[$];
    int unsigned mline;
    int unsigned msum;
    logic        merr;
    int unsigned exp_done_edge;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        got_q.delete();
        exp_q.delete();
        done_cnt      = 0;
        mline         = 0;
        msum          = 0;
        merr          = 1'b0;
        exp_done_edge = 0;
    endtask

    task automatic arm();
        ARM_I = 1'b1;
        step();
        ARM_I = 1'b0;
    endtask

    task automatic vs_pulse();
        vid.VSYNC_I = 1'b1;
        step();
        mline = 0;
        msum  = 0;
        step();
        vid.VSYNC_I = 1'b0;
    endtask

    // len pixels (value base+j, or random when base==0), then falling edge
    // and gap idle cycles unless no_end; modelled only when model_on.
    task automatic send_line(input int unsigned len, input int unsigned base,
                             input int unsigned gap, input bit model_on, input bit no_end);
        int unsigned v;
        for (int unsigned j = 0; j < len; j++) begin
            v = (base != 0) ? ((base + j) & 255) : $urandom_range(0, 255);
            vid.RGB_EN_I = 1'b1;
            vid.RGB_I    = 8'(v);
            step();
            if (model_on && j < H) begin
                exp_q.push_back(wr_t'{mline * H + j, v, ecnt + 1});
                msum = (msum + v) & 32'hFFFF;
            end
        end
        if (!no_end) begin
            vid.RGB_EN_I = 1'b0;
            vid.RGB_I    = 8'($urandom_range(0, 255));
            step();
            if (model_on) begin
                if (len != H) merr = 1'b1;
                mline++;
                if (mline == V) exp_done_edge = ecnt;
            end
            for (int unsigned g = 1; g < gap; g++) step();
        end
    endtask

    task automatic check_frame(input string tag);
        int n;
        for (int i = 0; i < 30 && done_cnt == 0; i++) step();
        step();
        step();
        chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, ".done_edge"}, done_edge, exp_done_edge);
        chk({tag, ".busy_in_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, ".busy_after"}, 32'(BUSY_O), 32'd0);
        chk({tag, ".err"}, 32'(ERR_O), 32'(merr));
        chk({tag, ".n_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.w%0d.addr", tag, i), got_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s.w%0d.data", tag, i), got_q[i].data, exp_q[i].data);
            chk($sformatf("%s.w%0d.edge", tag, i), got_q[i].edg, exp_q[i].edg);
        end
`ifdef TFT_CAP_CHECKSUM_EN
        chk({tag, ".chksum"}, 32'(CHKSUM_O), msum);
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, ".we"},   32'(vid.BRAM_WE_O),   32'd0);
        chk({tag, ".addr"}, 32'(vid.BRAM_ADDR_O), 32'd0);
        chk({tag, ".data"}, 32'(vid.BRAM_DATA_O), 32'd0);
        chk({tag, ".busy"}, 32'(BUSY_O), 32'd0);
        chk({tag, ".done"}, 32'(DONE_O), 32'd0);
        chk({tag, ".err"},  32'(ERR_O),  32'd0);
        chk({tag, ".state"}, 32'(dut.state_q), 32'(IDLE));
`ifdef TFT_CAP_CHECKSUM_EN
        chk({tag, ".chksum"}, 32'(CHKSUM_O), 32'd0);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        ARM_I        = 1'b0;
        vid.VSYNC_I  = 1'b0;
        vid.RGB_EN_I = 1'b0;
        vid.RGB_I    = '0;
        begin_frame();
        repeat (3) step();
        check_idle_zero("reset");
        rst = 1'b0;
        step();

        // Nominal frame: values 1..12, checksum 78
        begin_frame();
        arm();
        chk("nominal.busy_after_arm", 32'(BUSY_O), 32'd1);
        vs_pulse();
        send_line(4, 1, 2, 1, 0);
        chk("nominal.busy_capture", 32'(BUSY_O), 32'd1);
        send_line(4, 5, 2, 1, 0);
        send_line(4, 9, 2, 1, 0);
        check_frame("nominal");
`ifdef TFT_CAP_CHECKSUM_EN
        chk("nominal.chksum78", 32'(CHKSUM_O), 32'd78);
`endif

        // Short line 1
        begin_frame();
        arm();
        vs_pulse();
        send_line(4, 0, 2, 1, 0);
        send_line(3, 0, 2, 1, 0);
        send_line(4, 0, 2, 1, 0);
        check_frame("short");

        // Long line 0
        begin_frame();
        arm();
        chk("long.err_cleared", 32'(ERR_O), 32'd0);
        vs_pulse();
        send_line(6, 0, 2, 1, 0);
        send_line(4, 0, 2, 1, 0);
        send_line(4, 0, 2, 1, 0);
        check_frame("long");

        // Premature VSYNC after 1.5 lines, coinciding with the EN fall
        begin_frame();
        arm();
        vs_pulse();
        send_line(4, 0, 2, 1, 0);
        send_line(2, 0, 0, 1, 1);
        vid.RGB_EN_I = 1'b0;
        vid.VSYNC_I  = 1'b1;
        step();
        mline = 0;
        msum  = 0;
        merr  = 1'b1;
        step();
        vid.VSYNC_I = 1'b0;
        chk("premature.err", 32'(ERR_O), 32'd1);
        send_line(4, 0, 2, 1, 0);
        send_line(4, 0, 2, 1, 0);
        send_line(4, 0, 2, 1, 0);
        check_frame("premature");

        // Reset in the middle of line 1
        begin_frame();
        arm();
        vs_pulse();
        send_line(4, 0, 2, 0, 0);
        send_line(2, 0, 0, 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_zero("midreset");
        vid.RGB_EN_I = 1'b0;
        step();
        step();
        got_q.delete();
        vs_pulse();
        send_line(4, 0, 2, 0, 0);
        step();
        step();
        chk("midreset.no_writes", 32'(got_q.size()), 32'd0);
        chk("midreset.busy", 32'(BUSY_O), 32'd0);
        begin_frame();
        arm();
        vs_pulse();
        for (int unsigned l = 0; l < V; l++) send_line(4, 0, 2, 1, 0);
        check_frame("rearm");

        // Pixels in WAIT_VS, pixel on the VSYNC edge, ARM during CAPTURE
        begin_frame();
        arm();
        send_line(4, 0, 2, 0, 0);
        vid.VSYNC_I  = 1'b1;
        vid.RGB_EN_I = 1'b1;
        vid.RGB_I    = 8'hEE;
        step();
        vid.VSYNC_I = 1'b0;
        send_line(4, 0, 2, 1, 0);
        arm();
        send_line(4, 0, 2, 1, 0);
        send_line(4, 0, 2, 1, 0);
        check_frame("ignored");

        // Randomized frames
        for (int f = 0; f < 5; f++) begin
            begin_frame();
            arm();
            vs_pulse();
            for (int unsigned l = 0; l < V; l++)
                send_line($urandom_range(1, 6), 0, $urandom_range(1, 3), 1, 0);
            check_frame($sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
